router_pkt_reg: RTL and testbench
=================================

ROUTER_PKT_REG -- requirements
Module: router_pkt_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data byte width (>= ADDR_W+2).
REQ-002 SHALL have parameter ADDR_W, default 2, destination address field width in header.
REQ-003 SHALL have parameter ODD_PARITY, default 0: 0 = even (XOR) parity, 1 = odd (bitwise-inverted XOR) parity.
REQ-004 SHALL have parameter LEN_CHECK, default 1: 1 enables payload length checking.
REQ-005 SHALL have ports: clock input 1, rising-edge clock; resetn input 1, reset, synchronous, active-low.
REQ-006 SHALL have ports: pkt_valid input 1, source byte valid (high = header/payload, low after payload = parity byte on data_in); data_in input DATA_W, source byte.
REQ-007 SHALL have ports: fifo_full input 1, downstream FIFO cannot accept; soft_reset input 1, synchronous packet abort.
REQ-008 SHALL have ports: dout output DATA_W, byte to FIFO; dout_valid output 1, FIFO write strobe; dest_addr output ADDR_W, captured header address.
REQ-009 SHALL have ports: busy output 1, source must hold data_in; low_pkt_valid output 1, parity byte taken; parity_done output 1, check-complete pulse; err output 1, parity mismatch; len_err output 1, length mismatch.

Function
REQ-010 SHALL implement FSM states IDLE, HDR_OUT, LOAD, FULL, CHECK.
REQ-011 Header format SHALL be data_in[ADDR_W-1:0] = address, data_in[DATA_W-1:ADDR_W] = payload length L.
REQ-012 IDLE, pkt_valid=1: capture header into header register, dest_addr, and parity accumulator; clear payload count, err, len_err; go to HDR_OUT.
REQ-013 HDR_OUT: if fifo_full=0, drive header on dout with dout_valid=1 next cycle and go to LOAD; otherwise remain.
REQ-014 LOAD, pkt_valid=1: XOR data_in into accumulator and increment payload count (saturating at all-ones, no wrap).
REQ-015 In that case, if fifo_full=0, forward data_in on dout with dout_valid=1; otherwise store data_in in the hold register and go to FULL.
REQ-016 LOAD, pkt_valid=0: capture data_in as received parity, set low_pkt_valid.
REQ-017 In that case, forward the parity byte like payload (FULL if fifo_full=1, last flag set), otherwise go to CHECK.
REQ-018 FULL: when fifo_full=0, drive hold register on dout with dout_valid=1; go to CHECK if last flag set, else LOAD.
REQ-019 CHECK, one cycle: expected = accumulator, bitwise inverted if ODD_PARITY=1; err <= (received != expected).
REQ-020 In CHECK: len_err <= LEN_CHECK & (count != L); parity_done=1 for exactly that cycle; then go to IDLE.
REQ-021 err and len_err SHALL hold until the next header capture, soft_reset, or reset.
REQ-022 busy SHALL be 1 in HDR_OUT, FULL, CHECK; data_in SHALL NOT be sampled while busy=1.
REQ-023 Latency: a byte sampled at edge n SHALL appear on dout with dout_valid=1 after edge n+1 when fifo_full=0; every byte written exactly once, in order.
REQ-024 dout SHALL hold its last value when dout_valid=0; dout_valid SHALL never be 1 during a cycle in which fifo_full=1 was sampled.
REQ-025 low_pkt_valid SHALL stay 1 from the cycle after parity sampling until return to IDLE.
REQ-026 L=0: header followed directly by parity SHALL be legal, len_err=0.
REQ-027 soft_reset=1 SHALL win over all other inputs: next state IDLE; dout_valid, low_pkt_valid, parity_done, err, len_err, count, accumulator cleared; dout and dest_addr held.

Reset
REQ-028 resetn=0 at a clock edge SHALL set state IDLE and all outputs, registers, counters, and flags to zero, overriding soft_reset and in-flight packets.

Structure
REQ-029 Package router_pkg SHALL hold the FSM state enumeration and the header field slice constants.
REQ-030 Parity accumulation/compare SHALL be a sub-module router_parity_chk (clear, accumulate, compare; parameters DATA_W, ODD_PARITY).

Verification (DATA_W=8, ADDR_W=2)
REQ-031 Header 0x0D (addr 1, L=3), payload 0x11, 0x22, 0x33, parity 0x0D, fifo_full=0 -> dout 0D,11,22,33,0D; parity_done single pulse; err=0, len_err=0, dest_addr=1.
REQ-032 Same packet, parity 0x0C -> err=1, len_err=0; err holds until next header.
REQ-033 Same packet, fifo_full high 3 cycles while 0x22 offered -> 0x22 held, busy=1, 0x22 written exactly once after fifo_full drops, no loss.
REQ-034 Header 0x0D, payload 0x11, 0x22, parity 0x3E -> err=0, len_err=1; with LEN_CHECK=0 -> len_err=0.
REQ-035 soft_reset during payload 0x22 -> IDLE next cycle, flags 0; following normal packet passes cleanly; ODD_PARITY=1 with REQ-031 payload and parity 0xF2 -> err=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and header layout constants for the packet router register stage.
package router_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR_OUT,
      LOAD,
      FULL,
      CHECK
   } state_t;

   // The header carries the address in its low bits and the payload length above it.
   localparam int HDR_ADDR_LSB = 0;

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity accumulator with compare against a received parity byte.
module router_parity_chk #(
   parameter int DATA_W     = 8,
   parameter int ODD_PARITY = 0
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              clr,
   input  logic              acc_en,
   input  logic [DATA_W-1:0] acc_in,
   input  logic [DATA_W-1:0] rx_parity,
   output logic              mismatch
);

   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] acc_d;
   logic [DATA_W-1:0] expected;

   // Clear and accumulate together so a header byte seeds the accumulator directly.
   always_comb begin
      acc_d = clr ? '0 : acc_q;
      if (acc_en) begin
         acc_d = acc_d ^ acc_in;
      end
   end

   assign expected = (ODD_PARITY != 0) ? ~acc_q : acc_q;
   assign mismatch = (rx_parity != expected);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/router_pkt_reg.sv
// Packet register stage: forwards header/payload/parity bytes to a FIFO with back-pressure
// holding, and checks parity and payload length once the parity byte has been taken.
module router_pkt_reg
   import router_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 2,
   parameter int ODD_PARITY = 0,
   parameter int LEN_CHECK  = 1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              soft_reset,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic [ADDR_W-1:0] dest_addr,
   output logic              busy,
   output logic              low_pkt_valid,
   output logic              parity_done,
   output logic              err,
   output logic              len_err
);

   localparam int LEN_W = DATA_W - ADDR_W;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] hdr_q, hdr_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] rx_par_q, rx_par_d;
   logic              last_q, last_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;
   logic              busy_q, busy_d;
   logic              low_q, low_d;
   logic              pdone_q, pdone_d;
   logic              err_q, err_d;
   logic              len_err_q, len_err_d;

   logic              chk_clr;
   logic              chk_en;
   logic              chk_mismatch;

   router_parity_chk #(
      .DATA_W     (DATA_W),
      .ODD_PARITY (ODD_PARITY)
   ) u_parity (
      .clock     (clock),
      .resetn    (resetn),
      .clr       (chk_clr),
      .acc_en    (chk_en),
      .acc_in    (data_in),
      .rx_parity (rx_par_q),
      .mismatch  (chk_mismatch)
   );

   always_comb begin
      state_d      = state_q;
      hdr_d        = hdr_q;
      hold_d       = hold_q;
      rx_par_d     = rx_par_q;
      last_d       = last_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      dest_addr_d  = dest_addr_q;
      low_d        = low_q;
      err_d        = err_q;
      len_err_d    = len_err_q;
      chk_clr      = 1'b0;
      chk_en       = 1'b0;

      if (soft_reset) begin
         // Abort: dout and dest_addr keep their last values for the downstream side.
         state_d   = IDLE;
         low_d     = 1'b0;
         err_d     = 1'b0;
         len_err_d = 1'b0;
         count_d   = '0;
         last_d    = 1'b0;
         chk_clr   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (pkt_valid) begin
                  hdr_d       = data_in;
                  dest_addr_d = data_in[HDR_ADDR_LSB +: ADDR_W];
                  chk_clr     = 1'b1;
                  chk_en      = 1'b1;
                  count_d     = '0;
                  err_d       = 1'b0;
                  len_err_d   = 1'b0;
                  last_d      = 1'b0;
                  state_d     = HDR_OUT;
               end
            end
            HDR_OUT: begin
               if (!fifo_full) begin
                  dout_d       = hdr_q;
                  dout_valid_d = 1'b1;
                  state_d      = LOAD;
               end
            end
            LOAD: begin
               if (pkt_valid) begin
                  chk_en = 1'b1;
                  if (count_q != '1) begin
                     count_d = count_q + LEN_W'(1);
                  end
                  if (!fifo_full) begin
                     dout_d       = data_in;
                     dout_valid_d = 1'b1;
                  end else begin
                     hold_d  = data_in;
                     state_d = FULL;
                  end
               end else begin
                  rx_par_d = data_in;
                  low_d    = 1'b1;
                  if (fifo_full) begin
                     hold_d  = data_in;
                     last_d  = 1'b1;
                     state_d = FULL;
                  end else begin
                     dout_d       = data_in;
                     dout_valid_d = 1'b1;
                     state_d      = CHECK;
                  end
               end
            end
            FULL: begin
               if (!fifo_full) begin
                  dout_d       = hold_q;
                  dout_valid_d = 1'b1;
                  state_d      = last_q ? CHECK : LOAD;
               end
            end
            CHECK: begin
               err_d     = chk_mismatch;
               len_err_d = (LEN_CHECK != 0) && (count_q != hdr_q[DATA_W-1:HDR_ADDR_LSB+ADDR_W]);
               low_d     = 1'b0;
               last_d    = 1'b0;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // Status flags are registered from the next state so they line up with it.
      busy_d  = (state_d == HDR_OUT) || (state_d == FULL) || (state_d == CHECK);
      pdone_d = (state_d == CHECK);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= IDLE;
         hdr_q        <= '0;
         hold_q       <= '0;
         rx_par_q     <= '0;
         last_q       <= 1'b0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         dest_addr_q  <= '0;
         busy_q       <= 1'b0;
         low_q        <= 1'b0;
         pdone_q      <= 1'b0;
         err_q        <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_q        <= hdr_d;
         hold_q       <= hold_d;
         rx_par_q     <= rx_par_d;
         last_q       <= last_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dest_addr_q  <= dest_addr_d;
         busy_q       <= busy_d;
         low_q        <= low_d;
         pdone_q      <= pdone_d;
         err_q        <= err_d;
         len_err_q    <= len_err_d;
      end
   end

   assign dout          = dout_q;
   assign dout_valid    = dout_valid_q;
   assign dest_addr     = dest_addr_q;
   assign busy          = busy_q;
   assign low_pkt_valid = low_q;
   assign parity_done   = pdone_q;
   assign err           = err_q;
   assign len_err       = len_err_q;

endmodule

// File: tb/tb_router_pkt_reg.sv
// Bench for router_pkt_reg: default, odd-parity and no-length-check instances share one stimulus.
module tb_router_pkt_reg;

   logic       clock = 1'b0;
   logic       resetn, pkt_valid, fifo_full, soft_reset;
   logic [7:0] data_in;

   logic [7:0] dout, dout_o, dout_n;
   logic       dout_valid, dv_o, dv_n;
   logic [1:0] dest_addr, da_o, da_n;
   logic       busy, busy_o, busy_n;
   logic       low_pkt_valid, low_o, low_n;
   logic       parity_done, pd_o, pd_n;
   logic       err, err_o, err_n;
   logic       len_err, le_o, le_n;

   int         n_checks = 0;
   int         n_fail = 0;
   bit         rand_ff = 1'b0;
   int         viol = 0;
   logic [7:0] last_dout = '0;
   logic       ff_prev = 1'b0;
   logic       rst_prev = 1'b0;
   logic [7:0] got[$];

   typedef struct {
      logic [7:0]      hdr;
      int              n;
      logic [3:0][7:0] pl;
      logic [7:0]      par;
      int              stall_idx;
      logic [1:0]      addr;
      bit              err;
      bit              len;
      bit              err_odd;
   } vec_t;

   vec_t tbl[8];

   always #5 clock = ~clock;

   router_pkt_reg #(.DATA_W(8), .ADDR_W(2), .ODD_PARITY(0), .LEN_CHECK(1)) dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .soft_reset(soft_reset), .dout(dout), .dout_valid(dout_valid),
      .dest_addr(dest_addr), .busy(busy), .low_pkt_valid(low_pkt_valid),
      .parity_done(parity_done), .err(err), .len_err(len_err));

   router_pkt_reg #(.DATA_W(8), .ADDR_W(2), .ODD_PARITY(1), .LEN_CHECK(1)) dut_odd (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .soft_reset(soft_reset), .dout(dout_o), .dout_valid(dv_o),
      .dest_addr(da_o), .busy(busy_o), .low_pkt_valid(low_o),
      .parity_done(pd_o), .err(err_o), .len_err(le_o));

   router_pkt_reg #(.DATA_W(8), .ADDR_W(2), .ODD_PARITY(0), .LEN_CHECK(0)) dut_nolen (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .soft_reset(soft_reset), .dout(dout_n), .dout_valid(dv_n),
      .dest_addr(da_n), .busy(busy_n), .low_pkt_valid(low_n),
      .parity_done(pd_n), .err(err_n), .len_err(le_n));

   always @(posedge clock) begin
      ff_prev  <= fifo_full;
      rst_prev <= resetn;
   end

   // Collect FIFO writes; flag writes after a full cycle and dout drifting while not valid.
   always @(negedge clock) begin
      if (!rst_prev) begin
         last_dout <= dout;
      end else if (dout_valid) begin
         if (ff_prev) viol <= viol + 1;
         got.push_back(dout);
         last_dout <= dout;
      end else if (dout !== last_dout) begin
         viol <= viol + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic void ref_model(input logic [7:0] hdr, input int n, input logic [3:0][7:0] pl,
                                     input logic [7:0] par, output bit e, output bit l, output bit eo);
      logic [7:0] x;
      x = hdr;
      for (int i = 0; i < n; i++) x = x ^ pl[i];
      e  = (par != x);
      eo = (par != ~x);
      l  = (n != int'(hdr[7:2]));
   endfunction

   task automatic send_byte(input logic v, input logic [7:0] d, input bit stall);
      int g;
      pkt_valid = v;
      data_in   = d;
      if (stall) fifo_full = 1'b1;
      else if (rand_ff) fifo_full = ($urandom_range(0, 3) == 0);
      g = 0;
      while (busy && g < 100) begin
         @(negedge clock);
         g++;
         if (rand_ff && !stall) fifo_full = ($urandom_range(0, 3) == 0);
      end
      if (g >= 100) check("busy_timeout", 32'd1, 32'd0);
      @(negedge clock);
      if (stall) begin
         check("stall_busy", busy, 1);
         @(negedge clock);
         @(negedge clock);
         fifo_full = 1'b0;
      end
   endtask

   task automatic run_pkt(input logic [7:0] hdr, input int n, input logic [3:0][7:0] pl,
                          input logic [7:0] par, input int stall_idx, input logic [1:0] ex_addr,
                          input bit ex_err, input bit ex_len, input bit ex_err_odd);
      int         start, vbase, g;
      logic [7:0] exp_q[$];
      start = got.size();
      vbase = viol;
      exp_q.push_back(hdr);
      for (int i = 0; i < n; i++) exp_q.push_back(pl[i]);
      exp_q.push_back(par);
      send_byte(1'b1, hdr, stall_idx == 0);
      for (int i = 0; i < n; i++) send_byte(1'b1, pl[i], stall_idx == i + 1);
      send_byte(1'b0, par, stall_idx == n + 1);
      pkt_valid = 1'b0;
      data_in   = 8'($urandom);
      g = 0;
      while (!parity_done && g < 100) begin
         @(negedge clock);
         g++;
         if (rand_ff) fifo_full = ($urandom_range(0, 3) == 0);
      end
      fifo_full = 1'b0;
      check("parity_done_seen", parity_done, 1);
      check("low_pkt_valid_in_check", low_pkt_valid, 1);
      @(negedge clock);
      check("parity_done_single", parity_done, 0);
      check("low_pkt_valid_cleared", low_pkt_valid, 0);
      check("busy_idle", busy, 0);
      check("dest_addr", dest_addr, ex_addr);
      check("err", err, ex_err);
      check("len_err", len_err, ex_len);
      check("err_odd", err_o, ex_err_odd);
      check("len_err_odd", le_o, ex_len);
      check("err_nolen", err_n, ex_err);
      check("len_err_nolen", le_n, 0);
      check("stream_len", got.size() - start, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (start + i < got.size()) check("stream_byte", got[start + i], exp_q[i]);
      check("protocol", viol, vbase);
      $display("pkt hdr=%h n=%0d par=%h stall=%0d -> err=%b len_err=%b err_odd=%b writes=%0d",
               hdr, n, par, stall_idx, err, len_err, err_o, got.size() - start);
   endtask

   initial begin
      logic [3:0][7:0] pl3, pl2, pl1, zero4, rpl;
      int              start, n, len;
      logic [7:0]      hdr, par, acc;
      bit              e, l, eo;

      pl3   = {8'h00, 8'h33, 8'h22, 8'h11};
      pl2   = {8'h00, 8'h00, 8'h22, 8'h11};
      pl1   = {8'h00, 8'h00, 8'h00, 8'hAA};
      zero4 = '0;
      tbl[0] = '{8'h0D, 3, pl3,   8'h0D, -1, 2'd1, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{8'h0D, 3, pl3,   8'h0C, -1, 2'd1, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{8'h0D, 3, pl3,   8'h0D,  2, 2'd1, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{8'h0D, 2, pl2,   8'h3E, -1, 2'd1, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{8'h02, 0, zero4, 8'h02, -1, 2'd2, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{8'h0D, 3, pl3,   8'hF2, -1, 2'd1, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{8'hFF, 1, pl1,   8'h55,  2, 2'd3, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{8'h0D, 3, pl3,   8'h0D,  0, 2'd1, 1'b0, 1'b0, 1'b1};

      resetn = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0; soft_reset = 1'b0; data_in = '0;
      repeat (3) @(negedge clock);
      check("rst_dout", dout, 0);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dest_addr", dest_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_flags", {low_pkt_valid, parity_done, err, len_err}, 0);
      resetn = 1'b1;
      @(negedge clock);

      for (int k = 0; k < 8; k++)
         run_pkt(tbl[k].hdr, tbl[k].n, tbl[k].pl, tbl[k].par, tbl[k].stall_idx,
                 tbl[k].addr, tbl[k].err, tbl[k].len, tbl[k].err_odd);

      // err left set, then an idle soft_reset must clear it
      run_pkt(tbl[1].hdr, tbl[1].n, tbl[1].pl, tbl[1].par, -1, 2'd1, 1'b1, 1'b0, 1'b1);
      soft_reset = 1'b1;
      @(negedge clock);
      soft_reset = 1'b0;
      check("softrst_idle_err", err, 0);

      // soft_reset while 0x22 is offered
      start = got.size();
      send_byte(1'b1, 8'h0D, 1'b0);
      send_byte(1'b1, 8'h11, 1'b0);
      pkt_valid = 1'b1; data_in = 8'h22; soft_reset = 1'b1;
      @(negedge clock);
      soft_reset = 1'b0; pkt_valid = 1'b0;
      check("softrst_busy", busy, 0);
      check("softrst_dout_valid", dout_valid, 0);
      check("softrst_flags", {low_pkt_valid, parity_done, err, len_err}, 0);
      check("softrst_dest_held", dest_addr, 1);
      check("softrst_dout_held", dout, 8'h11);
      check("softrst_writes", got.size() - start, 2);
      $display("softrst mid-packet -> busy=%b dout=%h writes=%0d", busy, dout, got.size() - start);
      run_pkt(tbl[0].hdr, tbl[0].n, tbl[0].pl, tbl[0].par, -1, 2'd1, 1'b0, 1'b0, 1'b1);

      // randomized packets with random back-pressure against the reference model
      rand_ff = 1'b1;
      for (int k = 0; k < 40; k++) begin
         n   = $urandom_range(0, 4);
         len = ($urandom_range(0, 1) == 1) ? n : $urandom_range(0, 7);
         hdr = {6'(len), 2'($urandom_range(0, 3))};
         rpl = '0;
         for (int i = 0; i < n; i++) rpl[i] = 8'($urandom);
         acc = hdr;
         for (int i = 0; i < n; i++) acc = acc ^ rpl[i];
         case ($urandom_range(0, 2))
            0: par = acc;
            1: par = ~acc;
            default: par = 8'($urandom);
         endcase
         ref_model(hdr, n, rpl, par, e, l, eo);
         run_pkt(hdr, n, rpl, par, -1, hdr[1:0], e, l, eo);
      end
      rand_ff = 1'b0;
      fifo_full = 1'b0;

      // hard reset mid-packet overrides a simultaneous soft_reset
      send_byte(1'b1, 8'h0D, 1'b0);
      send_byte(1'b1, 8'h11, 1'b0);
      resetn = 1'b0; soft_reset = 1'b1; pkt_valid = 1'b1; data_in = 8'h22;
      @(negedge clock);
      check("hardrst_dout", dout, 0);
      check("hardrst_dest_addr", dest_addr, 0);
      check("hardrst_busy", busy, 0);
      check("hardrst_dout_valid", dout_valid, 0);
      $display("hard reset mid-packet -> dout=%h dest_addr=%0d busy=%b", dout, dest_addr, busy);
      resetn = 1'b1; soft_reset = 1'b0; pkt_valid = 1'b0;
      @(negedge clock);
      run_pkt(tbl[0].hdr, tbl[0].n, tbl[0].pl, tbl[0].par, -1, 2'd1, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
